// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Purpose: Shared definitions for the UART echo link: tester state encoding
//          and the default echo timeout.
// Ports  : (package, no ports)
// Rev    : 1.0  initial release
// ============================================================================
package uart_pkg;

   // Clocks allowed from a byte's tx_start to its echo rx_done.
   localparam int unsigned TIMEOUT_DEFAULT = 200000;

   // Echo tester state encoding.
   typedef logic [2:0] state_t;
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SEND    = 3'd1;
   localparam logic [2:0] ST_WAIT_TX = 3'd2;
   localparam logic [2:0] ST_WAIT_RX = 3'd3;
   localparam logic [2:0] ST_CHECK   = 3'd4;
   localparam logic [2:0] ST_FINISH  = 3'd5;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_echo_tester.sv
`default_nettype none
// ============================================================================
// Module : uart_echo_tester
// Purpose: Sends a numbered burst of bytes through uart_top's transmitter,
//          waits for each byte's echo on the receiver, compares it and
//          reports pass/fail, an error count and a sticky timeout flag.
// Ports  : clk, reset (sync, active low)
//          start, byte_count          burst request (0 = 256 bytes)
//          tx_start, tx_data, tx_done transmit handshake with uart_top
//          rx_done, rx_data           receive strobe from uart_top
//          busy, done, pass           burst status
//          err_count, timeout_seen    error reporting
//          last_rx                    most recent accepted echo byte
// Rev    : 1.0  initial release
// ============================================================================
module uart_echo_tester
   import uart_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
   parameter logic [7:0]  SEED           = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] byte_count,
   output logic       tx_start,
   output logic [7:0] tx_data,
   input  logic       tx_done,
   input  logic       rx_done,
   input  logic [7:0] rx_data,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic       timeout_seen,
   output logic [7:0] last_rx
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   state_t        state_q, state_d;
   logic [7:0]    idx_q, idx_d;
   logic [8:0]    rem_q, rem_d;
   logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          got_echo_q, got_echo_d;
   logic          tmo_pend_q, tmo_pend_d;
   logic          tx_start_q, tx_start_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          pass_q, pass_d;
   logic [7:0]    err_q, err_d;
   logic          tmo_seen_q, tmo_seen_d;
   logic [7:0]    last_rx_q, last_rx_d;

   // One extra bit so the increment cannot wrap before the compare.
   logic [CW:0]   w_cnt_inc;
   logic          w_hit;
   logic          w_bad;

   assign w_cnt_inc = {1'b0, tmo_cnt_q} + {{CW{1'b0}}, 1'b1};
   // ">=" rather than "==" so a tx_done arriving on the very last allowed
   // clock still times out in WAIT_RX instead of counting past the limit.
   assign w_hit     = (w_cnt_inc >= (CW + 1)'(TIMEOUT_CYCLES));
   assign w_bad     = tmo_pend_q || (last_rx_q != tx_data_q);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rem_d      = rem_q;
      tmo_cnt_d  = tmo_cnt_q;
      got_echo_d = got_echo_q;
      tmo_pend_d = tmo_pend_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      done_d     = 1'b0;
      pass_d     = pass_q;
      err_d      = err_q;
      tmo_seen_d = tmo_seen_q;
      last_rx_d  = last_rx_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_SEND;
               idx_d      = 8'd0;
               rem_d      = (byte_count == 8'd0) ? 9'd256 : {1'b0, byte_count};
               err_d      = 8'd0;
               tmo_seen_d = 1'b0;
               pass_d     = 1'b0;
               tx_start_d = 1'b1;
               tx_data_d  = SEED;
            end
         end

         ST_SEND: begin
            state_d    = ST_WAIT_TX;
            // The counter holds clocks elapsed since tx_start; the SEND
            // cycle itself is the first of them.
            tmo_cnt_d  = {{(CW-1){1'b0}}, 1'b1};
            got_echo_d = 1'b0;
            tmo_pend_d = 1'b0;
         end

         ST_WAIT_TX: begin
            tmo_cnt_d = w_cnt_inc[CW-1:0];
            // An early echo is latched here and carried into WAIT_RX.
            if (rx_done && !got_echo_q) begin
               last_rx_d  = rx_data;
               got_echo_d = 1'b1;
            end
            if (tx_done) begin
               state_d = ST_WAIT_RX;
            end else if (w_hit) begin
               state_d    = ST_CHECK;
               tmo_pend_d = 1'b1;
            end
         end

         ST_WAIT_RX: begin
            tmo_cnt_d = w_cnt_inc[CW-1:0];
            if (got_echo_q) begin
               state_d = ST_CHECK;
            end else if (rx_done) begin
               last_rx_d  = rx_data;
               got_echo_d = 1'b1;
               state_d    = ST_CHECK;
            end else if (w_hit) begin
               state_d    = ST_CHECK;
               tmo_pend_d = 1'b1;
            end
         end

         ST_CHECK: begin
            if (w_bad && (err_q != 8'hFF)) begin
               err_d = err_q + 8'd1;
            end
            if (tmo_pend_q) begin
               tmo_seen_d = 1'b1;
            end
            got_echo_d = 1'b0;
            idx_d      = idx_q + 8'd1;
            rem_d      = rem_q - 9'd1;
            if (rem_q == 9'd1) begin
               state_d = ST_FINISH;
               done_d  = 1'b1;
               pass_d  = (err_d == 8'd0);
            end else begin
               state_d    = ST_SEND;
               tx_start_d = 1'b1;
               tx_data_d  = SEED + idx_q + 8'd1;
            end
         end

         ST_FINISH: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_SEND)    || (state_d == ST_WAIT_TX) ||
               (state_d == ST_WAIT_RX) || (state_d == ST_CHECK);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         idx_q      <= 8'd0;
         rem_q      <= 9'd0;
         tmo_cnt_q  <= '0;
         got_echo_q <= 1'b0;
         tmo_pend_q <= 1'b0;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         err_q      <= 8'd0;
         tmo_seen_q <= 1'b0;
         last_rx_q  <= 8'd0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         rem_q      <= rem_d;
         tmo_cnt_q  <= tmo_cnt_d;
         got_echo_q <= got_echo_d;
         tmo_pend_q <= tmo_pend_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         err_q      <= err_d;
         tmo_seen_q <= tmo_seen_d;
         last_rx_q  <= last_rx_d;
      end
   end

   assign tx_start     = tx_start_q;
   assign tx_data      = tx_data_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign err_count    = err_q;
   assign timeout_seen = tmo_seen_q;
   assign last_rx      = last_rx_q;

endmodule : uart_echo_tester
`default_nettype wire

// File: tb/tb_uart_echo_tester.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_echo_tester
// Purpose: Self-checking bench for uart_echo_tester. Two instances: one with
//          SEED 0x41 and a short timeout driven by a fault-injecting echo
//          model, one with SEED 0xF0 running a full 256-byte burst.
// Ports  : (none)
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_echo_tester;

   localparam int TX_LAT = 20;
   localparam int RX_LAT = 50;
   localparam int M_NORMAL = 0;
   localparam int M_COINC  = 1;
   localparam int M_EARLY  = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT A ----------------
   logic       a_start = 1'b0;
   logic [7:0] a_byte_count = 8'd0;
   logic       a_tx_start, a_busy, a_done, a_pass, a_tmo;
   logic [7:0] a_tx_data, a_err, a_last_rx;
   logic       a_tx_done = 1'b0, a_rx_done = 1'b0;
   logic [7:0] a_rx_data = 8'd0;

   uart_echo_tester #(.TIMEOUT_CYCLES(100), .SEED(8'h41)) dut_a (
      .clk(clk), .reset(rst_n), .start(a_start), .byte_count(a_byte_count),
      .tx_start(a_tx_start), .tx_data(a_tx_data), .tx_done(a_tx_done),
      .rx_done(a_rx_done), .rx_data(a_rx_data), .busy(a_busy), .done(a_done),
      .pass(a_pass), .err_count(a_err), .timeout_seen(a_tmo), .last_rx(a_last_rx)
   );

   // ---------------- DUT B ----------------
   logic       b_start = 1'b0;
   logic [7:0] b_byte_count = 8'd0;
   logic       b_tx_start, b_busy, b_done, b_pass, b_tmo;
   logic [7:0] b_tx_data, b_err, b_last_rx;
   logic       b_tx_done = 1'b0, b_rx_done = 1'b0;
   logic [7:0] b_rx_data = 8'd0;

   uart_echo_tester #(.SEED(8'hF0)) dut_b (
      .clk(clk), .reset(rst_n), .start(b_start), .byte_count(b_byte_count),
      .tx_start(b_tx_start), .tx_data(b_tx_data), .tx_done(b_tx_done),
      .rx_done(b_rx_done), .rx_data(b_rx_data), .busy(b_busy), .done(b_done),
      .pass(b_pass), .err_count(b_err), .timeout_seen(b_tmo), .last_rx(b_last_rx)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // ---------------- echo model A (fault injection) ----------------
   int m_mode = M_NORMAL, m_corrupt = -1, m_drop = -1;
   int mtx = 0, mrx = 0, mdup = 0, mbidx = 0, mcur = 0;
   logic [7:0] mdata = 8'd0;

   function automatic logic [7:0] echo_val(input int cur, input logic [7:0] d);
      return (cur == m_corrupt) ? 8'h00 : d;
   endfunction

   always @(posedge clk) begin
      a_tx_done <= 1'b0;
      a_rx_done <= 1'b0;
      if (!rst_n) begin
         mtx <= 0; mrx <= 0; mdup <= 0; mbidx <= 0;
      end else begin
         if (a_start && !a_busy) mbidx <= 0;
         if (a_tx_start) begin
            mtx   <= TX_LAT;
            mdata <= a_tx_data;
            mcur  <= mbidx;
            mbidx <= mbidx + 1;
         end else if (mtx != 0) begin
            mtx <= mtx - 1;
            if (mtx == 1) begin
               a_tx_done <= 1'b1;
               if (m_mode == M_COINC) begin
                  if (mcur != m_drop) begin
                     a_rx_done <= 1'b1;
                     a_rx_data <= echo_val(mcur, mdata);
                  end
                  mdup <= 3;
               end else if (m_mode == M_NORMAL) begin
                  mrx <= RX_LAT;
               end
            end
            if (m_mode == M_EARLY && mtx == 6 && mcur != m_drop) begin
               a_rx_done <= 1'b1;
               a_rx_data <= echo_val(mcur, mdata);
            end
         end
         if (mrx != 0) begin
            mrx <= mrx - 1;
            if (mrx == 1 && mcur != m_drop) begin
               a_rx_done <= 1'b1;
               a_rx_data <= echo_val(mcur, mdata);
            end
         end
         // Wrong-valued duplicates 1 and 3 cycles after the coincident echo.
         if (mdup != 0) begin
            mdup <= mdup - 1;
            if (mdup == 3 || mdup == 1) begin
               a_rx_done <= 1'b1;
               a_rx_data <= 8'hEE;
            end
         end
      end
   end

   // ---------------- echo model B (ideal loopback) ----------------
   int btx = 0, brx = 0;
   logic [7:0] bdata = 8'd0;
   always @(posedge clk) begin
      b_tx_done <= 1'b0;
      b_rx_done <= 1'b0;
      if (!rst_n) begin
         btx <= 0; brx <= 0;
      end else begin
         if (b_tx_start) begin
            btx <= 4; bdata <= b_tx_data;
         end else if (btx != 0) begin
            btx <= btx - 1;
            if (btx == 1) begin b_tx_done <= 1'b1; brx <= 10; end
         end
         if (brx != 0) begin
            brx <= brx - 1;
            if (brx == 1) begin b_rx_done <= 1'b1; b_rx_data <= bdata; end
         end
      end
   end

   // ---------------- scoreboards / monitors ----------------
   logic [7:0] qa[$];
   logic [7:0] qb[$];
   int   a_ntx = 0, a_rxcyc = 0, b_ntx = 0;
   bit   a_rx_pend = 1'b0, b_wrap = 1'b0;
   int   a_txcyc[8];
   logic [7:0] a_e, b_e, b_prev = 8'h00;

   always @(negedge clk) begin
      if (rst_n) begin
         if (a_tx_start) begin
            if (qa.size() == 0) begin
               checks++; errors++;
               $display("FAIL a_tx_unexpected actual=0x%0h required=none", a_tx_data);
            end else begin
               a_e = qa.pop_front();
               chk("a_tx_data", a_tx_data, a_e);
            end
            if (a_ntx < 8) a_txcyc[a_ntx] = cyc;
            a_ntx++;
            if (a_rx_pend && m_mode == M_NORMAL) chk("a_rx_to_tx_gap", cyc - a_rxcyc, 2);
            a_rx_pend = 1'b0;
         end
         if (a_rx_done && !a_rx_pend) begin
            a_rx_pend = 1'b1;
            a_rxcyc   = cyc;
         end
         if (a_done && a_rx_pend && m_mode == M_NORMAL) begin
            chk("a_rx_to_done_gap", cyc - a_rxcyc, 2);
            a_rx_pend = 1'b0;
         end
         if (b_tx_start) begin
            if (qb.size() == 0) begin
               checks++; errors++;
               $display("FAIL b_tx_unexpected actual=0x%0h required=none", b_tx_data);
            end else begin
               b_e = qb.pop_front();
               chk("b_tx_data", b_tx_data, b_e);
            end
            if (b_ntx > 0 && b_prev == 8'hFF && b_tx_data == 8'h00) b_wrap = 1'b1;
            b_prev = b_tx_data;
            b_ntx++;
         end
      end
   end

   // ---------------- vectors ----------------
   typedef struct {
      int   mode;
      int   n;
      int   corrupt;
      int   drop;
      bit   busy_start;
      int   err;
      bit   pass;
      bit   tmo;
      int   last;
   } vec_t;

   vec_t vecs[7];

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_tx_start"}, a_tx_start, 0);
      chk({tag, "_tx_data"},  a_tx_data,  0);
      chk({tag, "_busy"},     a_busy,     0);
      chk({tag, "_done"},     a_done,     0);
      chk({tag, "_pass"},     a_pass,     0);
      chk({tag, "_err"},      a_err,      0);
      chk({tag, "_tmo"},      a_tmo,      0);
      chk({tag, "_last_rx"},  a_last_rx,  0);
   endtask

   task automatic run_burst_a(input vec_t v, input int id);
      int w;
      string tg;
      tg = $sformatf("v%0d", id);
      qa.delete();
      for (int i = 0; i < v.n; i++) qa.push_back(8'(8'h41 + i));
      m_mode = v.mode; m_corrupt = v.corrupt; m_drop = v.drop;
      a_ntx = 0; a_rx_pend = 1'b0;
      @(negedge clk);
      a_start = 1'b1;
      a_byte_count = 8'(v.n);
      @(negedge clk);
      a_start = 1'b0;
      chk({tg, "_busy_after_start"}, a_busy, 1);
      chk({tg, "_tx_start_after_start"}, a_tx_start, 1);
      if (v.busy_start) begin
         repeat (5) @(negedge clk);
         a_start = 1'b1;
         a_byte_count = 8'd1;
         @(negedge clk);
         a_start = 1'b0;
      end
      w = 0;
      while (!a_done && w < v.n * 300 + 50) begin
         @(negedge clk);
         w++;
      end
      chk({tg, "_done_seen"}, a_done, 1);
      chk({tg, "_busy_at_done"}, a_busy, 0);
      chk({tg, "_err_count"}, a_err, v.err);
      chk({tg, "_pass"}, a_pass, v.pass);
      chk({tg, "_timeout_seen"}, a_tmo, v.tmo);
      chk({tg, "_last_rx"}, a_last_rx, v.last);
      chk({tg, "_tx_count"}, a_ntx, v.n);
      chk({tg, "_queue_left"}, qa.size(), 0);
      if (v.drop >= 0 && v.drop < v.n - 1)
         chk({tg, "_timeout_gap"}, a_txcyc[v.drop + 1] - a_txcyc[v.drop], 101);
      repeat (3) @(negedge clk);
      chk({tg, "_pass_held"}, a_pass, v.pass);
   endtask

   initial begin
      int w;
      //        mode      n  corr drop bs  err pass tmo last
      vecs[0] = '{M_NORMAL, 4, -1, -1, 1'b0, 0, 1'b1, 1'b0, 8'h44};
      vecs[1] = '{M_NORMAL, 4,  2, -1, 1'b0, 1, 1'b0, 1'b0, 8'h44};
      vecs[2] = '{M_NORMAL, 4, -1,  1, 1'b0, 1, 1'b0, 1'b1, 8'h44};
      vecs[3] = '{M_COINC,  4, -1, -1, 1'b1, 0, 1'b1, 1'b0, 8'h44};
      vecs[4] = '{M_EARLY,  3,  0, -1, 1'b0, 1, 1'b0, 1'b0, 8'h43};
      vecs[5] = '{M_NORMAL, 4,  0,  3, 1'b0, 2, 1'b0, 1'b1, 8'h43};
      vecs[6] = '{M_NORMAL, 1,  0, -1, 1'b0, 1, 1'b0, 1'b0, 8'h00};

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      chk("reset_b_busy", b_busy, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) run_burst_a(vecs[i], i);

      // Reset during WAIT_RX of byte 2.
      qa.delete();
      for (int i = 0; i < 4; i++) qa.push_back(8'(8'h41 + i));
      m_mode = M_NORMAL; m_corrupt = 1; m_drop = -1;
      a_ntx = 0; a_rx_pend = 1'b0;
      @(negedge clk);
      a_start = 1'b1; a_byte_count = 8'd4;
      @(negedge clk);
      a_start = 1'b0;
      w = 0;
      while (a_ntx < 3 && w < 1000) begin
         @(negedge clk);
         w++;
      end
      chk("midrst_reached_byte2", a_ntx, 3);
      repeat (40) @(negedge clk);
      chk("midrst_busy_before", a_busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrst");
      @(negedge clk);
      chk("midrst_tx_start_held", a_tx_start, 0);
      rst_n = 1'b1;
      qa.delete();
      run_burst_a(vecs[0], 7);

      // Full 256-byte burst on instance B, wrapping 0xFF -> 0x00.
      qb.delete();
      for (int i = 0; i < 256; i++) qb.push_back(8'(8'hF0 + i));
      b_ntx = 0; b_wrap = 1'b0;
      @(negedge clk);
      b_start = 1'b1; b_byte_count = 8'd0;
      @(negedge clk);
      b_start = 1'b0;
      chk("b_busy_after_start", b_busy, 1);
      w = 0;
      while (!b_done && w < 256 * 40 + 100) begin
         @(negedge clk);
         w++;
      end
      chk("b_done_seen", b_done, 1);
      chk("b_busy_at_done", b_busy, 0);
      chk("b_pass", b_pass, 1);
      chk("b_err_count", b_err, 0);
      chk("b_timeout_seen", b_tmo, 0);
      chk("b_last_rx", b_last_rx, 8'hEF);
      chk("b_tx_count", b_ntx, 256);
      chk("b_queue_left", qb.size(), 0);
      chk("b_wrap_seen", b_wrap, 1);

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_uart_echo_tester
`default_nettype wire

// File: doc/uart_echo_tester.md
# uart_echo_tester

Initiator for the UART echo link: sends a numbered burst of bytes through `uart_top`'s transmit side, waits for each byte to come back on the receive side, and checks the returned value. It sits beside `uart_top` in place of the echo logic on a tester board and exercises a remote echo responder over the serial line. It reports pass/fail, an error count and a timeout flag.

## Interface
- `TIMEOUT_CYCLES`, default 200000: clocks allowed from a byte's `tx_start` to its echo `rx_done`.
- `SEED`, default 8'h00: value of the first byte in a burst.
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `start`  input  1  one-cycle request to run a burst; sampled only in IDLE.
- `byte_count`  input  8  number of bytes in the burst, sampled with `start`; 0 means 256.
- `tx_start`  output  1  one-cycle pulse to `uart_top`.
- `tx_data`  output  8  byte to send; valid with `tx_start` and held until the next `tx_start`.
- `tx_done`  input  1  one-cycle pulse from `uart_top` when the stop bit has been sent.
- `rx_done`  input  1  one-cycle pulse from `uart_top` when a byte has been received.
- `rx_data`  input  8  received byte; valid while `rx_done` is high.
- `busy`  output  1  high from the cycle after `start` is accepted until `done`.
- `done`  output  1  one-cycle pulse at the end of the burst.
- `pass`  output  1  set with `done` when `err_count` == 0; held until the next accepted `start`.
- `err_count`  output  8  mismatches plus timeouts in the current burst; saturates at 255.
- `timeout_seen`  output  1  sticky; set if any byte in the burst timed out.
- `last_rx`  output  8  most recent echoed byte that was accepted.

## Operation
- States:
  - IDLE: accepts `start` and goes to SEND.
  - SEND: one cycle; drives `tx_start`=1 and `tx_data`=expected byte; goes to WAIT_TX.
  - WAIT_TX: waits for `tx_done`, then goes to WAIT_RX.
  - WAIT_RX: waits for the echo, then goes to CHECK.
  - CHECK: one cycle; compares, then goes to SEND if bytes remain, otherwise FINISH.
  - FINISH: one cycle; pulses `done`, then goes to IDLE.
- Expected byte i (0-based) = (`SEED` + i) mod 256. The burst counter wraps naturally: a 256-byte burst with SEED 0 sends 0x00..0xFF.
- Accepting `start` clears `err_count`, `timeout_seen`, `pass` and the byte index.
- Echo capture:
  - The first `rx_done` seen in WAIT_TX or WAIT_RX latches `rx_data` into `last_rx` and sets an internal `got_echo` flag.
  - An `rx_done` in WAIT_TX is held until `tx_done`. WAIT_RX then moves to CHECK on the next cycle.
  - Further `rx_done` pulses for the same byte are ignored.
  - `rx_done` in IDLE, SEND, CHECK or FINISH is ignored. Echoes cannot be lost here: serial latency is many clocks.
- Timeout:
  - Counter clears in SEND and increments every cycle in WAIT_TX and WAIT_RX.
  - If it reaches `TIMEOUT_CYCLES` without `got_echo`, go to CHECK with a timeout marked.
  - The timeout also applies if `tx_done` never arrives.
- CHECK:
  - On a mismatch or timeout, increment `err_count` (saturating at 255). A timeout also sets `timeout_seen`.
  - The byte index advances in either case, and `got_echo` clears.
- `start` while `busy` is ignored.
- Simultaneous `tx_done` and `rx_done` in WAIT_TX: the echo is latched and the state goes to WAIT_RX.
- Reset is active low and takes effect on any clock edge, including mid-burst. State goes to IDLE and all outputs return to reset values on that edge. `tx_start` is therefore never high in the cycle after reset is asserted.

## Timing
- Reset values: `tx_start` 0, `tx_data` 0, `busy` 0, `done` 0, `pass` 0, `err_count` 0, `timeout_seen` 0, `last_rx` 0.
- `start` in cycle N: `busy` = 1 and `tx_start` = 1 in cycle N+1.
- Echo `rx_done` in cycle M (state WAIT_RX): CHECK in M+1. The next `tx_start` is in M+2, or `done` is in M+2 for the last byte.
- Cycle of `done`: `busy` = 0 and `pass` / `err_count` are final.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Timeout counter width is $clog2(`TIMEOUT_CYCLES`+1).

## Structure
- Shared `uart_pkg`: state enum (IDLE, SEND, WAIT_TX, WAIT_RX, CHECK, FINISH) and the default timeout constant.
- Single module with no sub-modules. Instantiated next to `uart_top` at the tester top level.

## Test plan
- Loopback model that echoes `tx_data` as `rx_done` 50 cycles after `tx_done`; `byte_count`=4, `SEED`=8'h41 -> bytes 0x41..0x44 sent; `done` with `pass`=1, `err_count`=0.
- Model corrupts byte 2 (returns 0x00) -> `err_count`=1, `pass`=0, `timeout_seen`=0, `last_rx` ends at 0x44.
- Model drops byte 1, `TIMEOUT_CYCLES`=100 -> CHECK exactly 100 cycles after that byte's SEND; `err_count`=1, `timeout_seen`=1; remaining bytes still sent.
- `byte_count`=0, `SEED`=8'hF0 -> 256 bytes sent, covering the wrap 0xFF->0x00; `pass`=1.
- `rx_done` coincident with `tx_done`, plus a duplicate `rx_done` 3 cycles later -> one compare only, `err_count`=0; `start` pulsed while busy -> ignored.
- `reset` low during WAIT_RX of byte 2 -> next edge gives IDLE, `busy`=0, all outputs 0; a new `start` runs a clean burst.
